// File: rtl/fir_lpf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_lpf_pkg
// Description : Shared widths, FIR coefficients and the cosine lookup table
//               for the FIR low-pass self-test demonstrator.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_lpf_pkg;

    localparam int DIN_W   = 10;              // source sample width
    localparam int COEF_W  = 12;              // Q1.11 coefficient width
    localparam int ACC_W   = 26;              // accumulator width
    localparam int DOUT_W  = 13;              // output sample width
    localparam int NTAPS   = 16;              // filter length
    localparam int NHALF   = NTAPS / 2;       // unique coefficients (symmetric)
    localparam int PRE_W   = DIN_W + 1;       // pre-adder width
    localparam int PROD_W  = PRE_W + COEF_W;  // product width
    localparam int FRAC_SH = 11;              // Q1.11 fraction bits
    localparam int PH_W    = 16;              // phase accumulator width
    localparam int LUT_AW  = 6;               // LUT address width
    localparam int LUT_N   = 64;              // LUT depth

    typedef logic signed [DIN_W-1:0]  sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;

    // h0..h7; the upper half mirrors these (h[15-n] = h[n]). Sum of all = 2048.
    localparam coef_t COEF [0:NHALF-1] = '{
        -12'sd8, -12'sd12, 12'sd0, 12'sd48,
        12'sd128, 12'sd232, 12'sd320, 12'sd316
    };

    // round(255*cos(2*pi*k/64)), k = 0..63
    localparam sample_t COS_LUT [0:LUT_N-1] = '{
        10'sd255,  10'sd254,  10'sd250,  10'sd244,  10'sd236,  10'sd225,  10'sd212,  10'sd197,
        10'sd180,  10'sd162,  10'sd142,  10'sd120,  10'sd98,   10'sd74,   10'sd50,   10'sd25,
        10'sd0,   -10'sd25,  -10'sd50,  -10'sd74,  -10'sd98,  -10'sd120, -10'sd142, -10'sd162,
       -10'sd180, -10'sd197, -10'sd212, -10'sd225, -10'sd236, -10'sd244, -10'sd250, -10'sd254,
       -10'sd255, -10'sd254, -10'sd250, -10'sd244, -10'sd236, -10'sd225, -10'sd212, -10'sd197,
       -10'sd180, -10'sd162, -10'sd142, -10'sd120, -10'sd98,  -10'sd74,  -10'sd50,  -10'sd25,
        10'sd0,    10'sd25,   10'sd50,   10'sd74,   10'sd98,   10'sd120,  10'sd142,  10'sd162,
        10'sd180,  10'sd197,  10'sd212,  10'sd225,  10'sd236,  10'sd244,  10'sd250,  10'sd254
    };

endpackage : fir_lpf_pkg
`default_nettype wire

// File: rtl/fir_tone_src.sv
`default_nettype none
// ============================================================================
// Module      : fir_tone_src
// Description : Sample-rate divider and two-tone DDS. Emits the sum of two
//               cosine tones and a one-cycle strobe every SAMPLE_DIV clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_tone_src
    import fir_lpf_pkg::*;
#(
    parameter int          SAMPLE_DIV = 8,
    parameter logic [15:0] TONE_A_FCW = 16'h0200,
    parameter logic [15:0] TONE_B_FCW = 16'h6000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DIN_W-1:0]  o_sample,
    output logic              o_stb
);

    localparam int             CNT_W   = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [PH_W-1:0]  r_ph_a;
    logic [PH_W-1:0]  r_ph_b;
    logic             w_stb;
    sample_t          w_sample;
    logic             w_unused_ph;

    assign w_stb = (r_cnt == CNT_MAX);

    // The sample always reflects the current phases; it is captured by the
    // delay line on the strobe edge, at which point the phases advance.
    assign w_sample = COS_LUT[r_ph_a[PH_W-1 -: LUT_AW]] + COS_LUT[r_ph_b[PH_W-1 -: LUT_AW]];

    // Fractional phase bits only carry precision for the accumulation.
    assign w_unused_ph = ^{r_ph_a[PH_W-LUT_AW-1:0], r_ph_b[PH_W-LUT_AW-1:0]};

    // Divider: counts 0..SAMPLE_DIV-1 and wraps on the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_stb) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Phase accumulators advance once per sample, wrapping mod 2^16.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ph_a <= '0;
            r_ph_b <= '0;
        end else if (w_stb) begin
            r_ph_a <= r_ph_a + TONE_A_FCW;
            r_ph_b <= r_ph_b + TONE_B_FCW;
        end
    end

    assign o_sample = w_sample;
    assign o_stb    = w_stb;

endmodule : fir_tone_src
`default_nettype wire

// File: rtl/fir_lpf_selftest_top.sv
`default_nettype none
// ============================================================================
// Module      : fir_lpf_selftest_top
// Description : Self-contained FIR low-pass demonstrator: internal two-tone
//               source feeding a 16-tap symmetric FIR (DC gain 1) with a
//               three-stage pipeline (pre-add, multiply, sum/scale).
//               Build option FIR_ROUND_EN: round-half-up output scaling
//               instead of floor; latency is identical in both builds.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_lpf_selftest_top
    import fir_lpf_pkg::*;
#(
    parameter int          SAMPLE_DIV = 8,
    parameter logic [15:0] TONE_A_FCW = 16'h0200,
    parameter logic [15:0] TONE_B_FCW = 16'h6000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    output logic [DOUT_W-1:0] fir_out,
    output logic              fir_out_en
);

    logic [DIN_W-1:0]          w_sample;
    logic                      w_stb;

    logic signed [DIN_W-1:0]   r_x    [0:NTAPS-1];
    logic signed [PRE_W-1:0]   r_pre  [0:NHALF-1];
    logic signed [PROD_W-1:0]  r_prod [0:NHALF-1];
    logic                      r_ld;
    logic                      r_v1;
    logic                      r_v2;

    logic signed [ACC_W-1:0]   w_acc;
    logic signed [ACC_W-1:0]   w_acc_adj;
    logic                      w_unused_acc;

    fir_tone_src #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .TONE_A_FCW (TONE_A_FCW),
        .TONE_B_FCW (TONE_B_FCW)
    ) u_src (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .o_sample (w_sample),
        .o_stb    (w_stb)
    );

    // Delay line: newest sample enters at x[0] on every strobe.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_x[i] <= '0;
            end
        end else if (w_stb) begin
            r_x[0] <= $signed(w_sample);
            for (int i = 1; i < NTAPS; i++) begin
                r_x[i] <= r_x[i-1];
            end
        end
    end

    // S1/S2: fold symmetric taps, then multiply by the shared coefficient.
    // Both stages run every cycle; only the valid chain qualifies the result.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int n = 0; n < NHALF; n++) begin
                r_pre[n]  <= '0;
                r_prod[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NHALF; n++) begin
                r_pre[n]  <= PRE_W'(r_x[n]) + PRE_W'(r_x[NTAPS-1-n]);
                r_prod[n] <= PROD_W'(r_pre[n]) * PROD_W'(COEF[n]);
            end
        end
    end

    // Valid chain: delay-line load -> S1 -> S2 -> output register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_ld <= 1'b0;
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_ld <= w_stb;
            r_v1 <= r_ld;
            r_v2 <= r_v1;
        end
    end

    // S3 adder tree plus optional rounding offset ahead of the Q1.11 shift.
    always_comb begin
        w_acc = '0;
        for (int n = 0; n < NHALF; n++) begin
            w_acc = w_acc + ACC_W'(r_prod[n]);
        end
`ifdef FIR_ROUND_EN
        w_acc_adj = w_acc + ACC_W'(1 << (FRAC_SH - 1));
`else
        w_acc_adj = w_acc;
`endif
    end

    // Result never exceeds +/-530, so the sign bits above the output slice
    // and the discarded fraction bits carry no information.
    assign w_unused_acc = ^{w_acc_adj[ACC_W-1:FRAC_SH+DOUT_W], w_acc_adj[FRAC_SH-1:0]};

    // Output register: bit slice equals arithmetic shift by FRAC_SH; value
    // holds between strobes.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            fir_out    <= '0;
            fir_out_en <= 1'b0;
        end else begin
            fir_out_en <= r_v2;
            if (r_v2) begin
                fir_out <= w_acc_adj[FRAC_SH +: DOUT_W];
            end
        end
    end

endmodule : fir_lpf_selftest_top
`default_nettype wire

// File: tb/tb_fir_lpf_selftest_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_lpf_selftest_top
// Description : Self-checking bench. Three instances (default tones, constant
//               input, Nyquist-alternating input with a shorter divider) are
//               checked every cycle against a closed-form reference built from
//               the tone/filter definitions. Reset timing is randomized.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_lpf_selftest_top;

    localparam int D_DFLT = 8;
    localparam int D_DC   = 8;
    localparam int D_NYQ  = 5;

    logic        sys_clk;
    logic        sys_rst;
    logic [12:0] dflt_out, dc_out, nyq_out;
    logic        dflt_en,  dc_en,  nyq_en;

    int n_checks = 0;
    int n_errors = 0;
    int edges    = 0;
    int lut [0:63];
    int h   [0:15];

    fir_lpf_selftest_top u_dflt (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .fir_out(dflt_out), .fir_out_en(dflt_en)
    );

    fir_lpf_selftest_top #(.SAMPLE_DIV(D_DC), .TONE_A_FCW(16'h0000), .TONE_B_FCW(16'h0000)) u_dc (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .fir_out(dc_out), .fir_out_en(dc_en)
    );

    fir_lpf_selftest_top #(.SAMPLE_DIV(D_NYQ), .TONE_A_FCW(16'h0000), .TONE_B_FCW(16'h8000)) u_nyq (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .fir_out(nyq_out), .fir_out_en(nyq_en)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Reference tables derived from the filter and tone definitions.
    initial begin
        int base [0:7];
        real c;
        base = '{-8, -12, 0, 48, 128, 232, 320, 316};
        for (int n = 0; n < 8; n++) begin
            h[n]      = base[n];
            h[15 - n] = base[n];
        end
        for (int k = 0; k < 64; k++) begin
            c = 255.0 * $cos(2.0 * 3.14159265358979 * k / 64.0);
            lut[k] = (c >= 0.0) ? $rtoi(c + 0.5) : -$rtoi(-c + 0.5);
        end
    end

    // Rising edges since reset release.
    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) edges <= 0;
        else         edges <= edges + 1;
    end

    task automatic check_val(input string tag, input int obs, input int req);
        n_checks++;
        if (obs != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, req, $time);
        end
    endtask

    // j-th source sample after reset (j >= 1), zero before the first.
    function automatic int samp(input int j, input int fa, input int fb);
        int pa, pb;
        if (j < 1) return 0;
        pa = ((j - 1) * fa) & 32'hFFFF;
        pb = ((j - 1) * fb) & 32'hFFFF;
        return lut[(pa >> 10) & 63] + lut[(pb >> 10) & 63];
    endfunction

    // m-th filter output: direct-form convolution and Q1.11 scaling.
    function automatic int fir_ref(input int m, input int fa, input int fb);
        int acc;
        acc = 0;
        for (int k = 0; k < 16; k++) acc += h[k] * samp(m - k, fa, fb);
`ifdef FIR_ROUND_EN
        acc += 1024;
`endif
        return acc >>> 11;
    endfunction

    task automatic check_dut(input string nm, input int d, input int fa, input int fb,
                             input int obs_out, input int obs_en,
                             output int m, output int req_en);
        int req_out;
        if (sys_rst) begin
            req_en  = 0;
            req_out = 0;
            m       = 0;
        end else begin
            req_en  = int'((edges >= d + 3) && (((edges - 3) % d) == 0));
            m       = (edges >= d + 3) ? (edges - 3) / d : 0;
            req_out = (m > 0) ? fir_ref(m, fa, fb) : 0;
        end
        check_val({nm, "_en"},  obs_en,  req_en);
        check_val({nm, "_out"}, obs_out, req_out);
    endtask

    // Cycle-by-cycle comparison on the falling edge.
    always @(negedge sys_clk) begin
        int m, e, o;
        check_dut("dflt", D_DFLT, 16'h0200, 16'h6000, $signed(dflt_out), int'(dflt_en), m, e);
        o = $signed(dflt_out);
        if (e == 1) check_val("dflt_range", int'(o <= 530 && o >= -530), 1);

        check_dut("dc", D_DC, 0, 0, $signed(dc_out), int'(dc_en), m, e);
        if (e == 1 && m == 1)  check_val("dc_first",   $signed(dc_out), -2);
        if (e == 1 && m == 2)  check_val("dc_second",  $signed(dc_out), -5);
        if (e == 1 && m >= 16) check_val("dc_settled", $signed(dc_out), 510);

        check_dut("nyq", D_NYQ, 0, 16'h8000, $signed(nyq_out), int'(nyq_en), m, e);
        if (e == 1 && m >= 16) check_val("nyq_steady", $signed(nyq_out), 255);
    end

    // Release reset away from the clock edge and time the first strobe.
    task automatic release_and_time();
        int found;
        @(negedge sys_clk);
        #1 sys_rst = 1'b0;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge sys_clk);
            #1;
            if (dc_en) begin
                found = 1;
                break;
            end
        end
        check_val("first_pulse_edge", found ? edges : -1, D_DC + 3);
    endtask

    task automatic async_reset(input int cycles);
        @(posedge sys_clk);
        #($urandom_range(1, 4));
        sys_rst = 1'b1;
        #1;
        check_val("async_clr_dflt_out", $signed(dflt_out), 0);
        check_val("async_clr_dc_out",   $signed(dc_out),   0);
        check_val("async_clr_nyq_out",  $signed(nyq_out),  0);
        check_val("async_clr_en", int'(dflt_en | dc_en | nyq_en), 0);
        repeat (cycles) @(posedge sys_clk);
    endtask

    initial begin
        sys_rst = 1'b1;
        repeat ($urandom_range(3, 6)) @(negedge sys_clk);
        check_val("rst_dc_out", $signed(dc_out), 0);
        check_val("rst_en", int'(dflt_en | dc_en | nyq_en), 0);
        release_and_time();
        repeat ($urandom_range(250, 350)) @(posedge sys_clk);

        async_reset(3);
        release_and_time();
        repeat ($urandom_range(150, 300)) @(posedge sys_clk);

        for (int r = 0; r < 3; r++) begin
            async_reset($urandom_range(1, 5));
            release_and_time();
            repeat ($urandom_range(40, 220)) @(posedge sys_clk);
        end

        @(negedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fir_lpf_selftest_top
`default_nettype wire
